// File: rtl/shift_unit_seq.sv
// Multicycle shifter: latches an operand and a 5-bit amount, then moves data_out
// by one bit position per clock and pulses done when the result is final.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shamt_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_shift_op;

    // Amount bits above the slice only matter modulo 32, so they are dropped.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt_in[31:SHW];

    assign is_shift_op = (op == OP_SLL) || (op == OP_SRL) ||
                         (op == OP_SRA) || (op == OP_ROR);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    data_d  = data_in;
                    count_d = shamt_in[SHW-1:0];
                    if (is_shift_op && (shamt_in[SHW-1:0] != CNT_ZERO)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  data_d = {data_q[WIDTH-2:0], 1'b0};
                    OP_SRL:  data_d = {1'b0, data_q[WIDTH-1:1]};
                    OP_SRA:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    OP_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                    default: data_d = data_q;
                endcase
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A start arriving here is dropped; the next one is taken from IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            data_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: a vector table for single requests plus
// hand-written sequences for reset, busy protection and abort behaviour.
module tb_shift_unit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [31:0] shamt_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int total;
    int bad;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] din;
        logic [31:0] shamt;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    shift_unit_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt_in (shamt_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        op       = 3'($urandom_range(0, 7));
        data_in  = $urandom;
        shamt_in = $urandom;
    endtask

    // Drives one request in cycle T and follows it to its done pulse.
    task automatic run_request(input logic [2:0] o, input logic [31:0] d, input logic [31:0] sh,
                               input logic [31:0] exp_data, input int exp_lat, input string name);
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; op = o; data_in = d; shamt_in = sh;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) begin
                seen = k;
                break;
            end
            check({name, "_busy"}, 32'(busy), 32'd1);
        end
        check({name, "_latency"}, 32'(seen), 32'(exp_lat));
        check({name, "_data"}, data_out, exp_data);
        check({name, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, "_done_low"}, 32'(done), 32'd0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_data_hold"}, data_out, exp_data);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        op = 3'b000; data_in = '0; shamt_in = '0;

        vecs[0]  = '{3'b001, 32'h0000_0001, 32'd4,          32'h0000_0010, 5};
        vecs[1]  = '{3'b011, 32'h8000_0000, 32'h0000_0021,  32'hC000_0000, 2};
        vecs[2]  = '{3'b010, 32'h8000_0000, 32'h0000_0021,  32'h4000_0000, 2};
        vecs[3]  = '{3'b100, 32'h0000_0003, 32'd31,         32'h0000_0006, 32};
        vecs[4]  = '{3'b100, 32'h0000_0003, 32'd0,          32'h0000_0003, 1};
        vecs[5]  = '{3'b000, 32'hA5A5_5A5A, 32'd7,          32'hA5A5_5A5A, 1};
        vecs[6]  = '{3'b111, 32'h0000_1234, 32'd5,          32'h0000_1234, 1};
        vecs[7]  = '{3'b001, 32'hFFFF_FFFF, 32'd32,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{3'b011, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 32};
        vecs[9]  = '{3'b010, 32'hF000_000F, 32'd4,          32'h0F00_0000, 5};
        vecs[10] = '{3'b001, 32'h8000_0001, 32'd1,          32'h0000_0002, 2};
        vecs[11] = '{3'b100, 32'h1234_5678, 32'd4,          32'h8123_4567, 5};
        vecs[12] = '{3'b011, 32'h7000_0000, 32'd3,          32'h0E00_0000, 4};

        // reset held two cycles, then idle with no start
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_data", data_out, 32'h0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        foreach (vecs[i]) begin
            run_request(vecs[i].op, vecs[i].din, vecs[i].shamt, vecs[i].exp_data,
                        vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // busy protection: second start mid-shift and a start on the DONE edge are dropped
        begin
            int done_cnt;
            done_cnt = 0;
            @(negedge clk);
            start = 1'b1; op = 3'b100; data_in = 32'h1234_5678; shamt_in = 32'd8;
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (k > 1) @(negedge clk);
                if (k == 3) begin
                    start = 1'b1; op = 3'b001; data_in = 32'h0; shamt_in = 32'd5;
                end else if (k == 9) begin
                    start = 1'b1; op = 3'b000; data_in = 32'hCAFE_F00D; shamt_in = 32'd0;
                end else begin
                    start = 1'b0;
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    check("busyprot_done_cycle", 32'(k), 32'd9);
                end
                if (k < 10) check("busyprot_busy_hi", 32'(busy), 32'd1);
                else        check("busyprot_busy_lo", 32'(busy), 32'd0);
            end
            check("busyprot_done_count", 32'(done_cnt), 32'd1);
            check("busyprot_data", data_out, 32'h7812_3456);
        end

        // reset mid-shift aborts without a done pulse
        begin
            int done_cnt;
            done_cnt = 0;
            @(negedge clk);
            start = 1'b1; op = 3'b001; data_in = 32'h0000_0001; shamt_in = 32'd20;
            @(negedge clk);
            start = 1'b0;
            for (int k = 2; k <= 6; k++) @(negedge clk);
            check("abort_busy_before", 32'(busy), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_data", data_out, 32'h0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (done === 1'b1) done_cnt++;
            end
            check("abort_no_done", 32'(done_cnt), 32'd0);
            check("abort_data_idle", data_out, 32'h0);
        end
        run_request(3'b000, 32'hDEAD_BEEF, 32'd9, 32'hDEAD_BEEF, 1, "post_abort_load");

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 3'b000; data_in = 32'h0000_0055;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_data", data_out, 32'h0);
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start_busy_after", 32'(busy), 32'd0);
        check("rst_start_done_after", 32'(done), 32'd0);
        check("rst_start_data_after", data_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
